// File: rtl/fir_tdm_pkg.sv
// rtl/fir_tdm_pkg.sv - shared constants and types for the TDM FIR sequencer
package fir_tdm_pkg;
    localparam int DW_DEF       = 16;
    localparam int MAX_N_CH     = 16;
    localparam int INFLIGHT_DEF = 32;
    localparam int CH_IDX_W     = $clog2(MAX_N_CH);

    typedef logic [CH_IDX_W-1:0] ch_idx_t;
endpackage

// File: rtl/fir_tdm_hold.sv
// rtl/fir_tdm_hold.sv - single-entry per-channel sample holding register
module fir_tdm_hold
    import fir_tdm_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [DW-1:0] s_tdata,
    input  logic          take,
    output logic          full,
    output logic [DW-1:0] data
);
    assign s_tready = !full;

    // Load only while empty and drain only while full, so the two never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (s_tvalid && !full) begin
            full <= 1'b1;
            data <= s_tdata;
        end else if (take) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/fir_tdm_sequencer.sv
// rtl/fir_tdm_sequencer.sv - time-division sequencer feeding one FIR core with N interleaved channels
module fir_tdm_sequencer
    import fir_tdm_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DW           = DW_DEF,
    parameter int MAX_INFLIGHT = INFLIGHT_DEF
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     enable,
    input  logic [N_CH-1:0]          s_ch_tvalid,
    output logic [N_CH-1:0]          s_ch_tready,
    input  logic [N_CH*DW-1:0]       s_ch_tdata,
    output logic                     fir_s_tvalid,
    input  logic                     fir_s_tready,
    output logic [DW-1:0]            fir_s_tdata,
    input  logic                     fir_m_tvalid,
    input  logic [DW-1:0]            fir_m_tdata,
    output logic                     m_tvalid,
    output logic [DW-1:0]            m_tdata,
    output logic [$clog2(N_CH)-1:0]  m_tuser,
    output logic                     m_tlast,
    output logic                     err_underflow,
    output logic                     err_overflow
);
    localparam int CH_W = $clog2(N_CH);
    localparam int IW   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    localparam logic [IW-1:0]   INF_MAX = IW'(MAX_INFLIGHT);

    logic [N_CH-1:0] full;
    logic [N_CH-1:0] take;
    logic [DW-1:0]   hold_data [N_CH];
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] out_ptr;
    logic [IW-1:0]   inflight;
    logic            issue;
    logic            ret;

    for (genvar i = 0; i < N_CH; i++) begin : g_hold
        assign take[i] = issue && (ptr == CH_W'(i));

        fir_tdm_hold #(.DW(DW)) u_hold (
            .clk      (aclk),
            .rst_n    (aresetn),
            .s_tvalid (s_ch_tvalid[i]),
            .s_tready (s_ch_tready[i]),
            .s_tdata  (s_ch_tdata[i*DW +: DW]),
            .take     (take[i]),
            .full     (full[i]),
            .data     (hold_data[i])
        );
    end

    // Strict round robin: an empty slot at ptr stalls issue even if later channels are loaded.
    assign fir_s_tvalid = enable && full[ptr] && (inflight < INF_MAX);
    assign fir_s_tdata  = hold_data[ptr];
    assign issue        = fir_s_tvalid && fir_s_tready;
    assign ret          = fir_m_tvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (ptr == LAST_CH) ? '0 : ptr + CH_W'(1);
        end
    end

    // Issue and return in the same cycle cancel; a return with nothing in flight leaves the count at 0.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inflight      <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (ret && (inflight == '0)) begin
                err_underflow <= 1'b1;
            end
            if (issue && !ret) begin
                if (inflight == INF_MAX) begin
                    err_overflow <= 1'b1;
                end else begin
                    inflight <= inflight + IW'(1);
                end
            end else if (!issue && ret && (inflight != '0)) begin
                inflight <= inflight - IW'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= '0;
            m_tlast  <= 1'b0;
            out_ptr  <= '0;
        end else begin
            m_tvalid <= ret;
            if (ret) begin
                m_tdata <= fir_m_tdata;
                m_tuser <= out_ptr;
                m_tlast <= (out_ptr == LAST_CH);
                out_ptr <= (out_ptr == LAST_CH) ? '0 : out_ptr + CH_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// tb/tb_fir_tdm_sequencer.sv - self-checking bench for fir_tdm_sequencer with a delay-line core model
module tb_fir_tdm_sequencer;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  s_ch_tvalid = '0;
    logic [3:0]  s_ch_tready;
    logic [63:0] s_ch_tdata = '0;
    logic        fir_s_tvalid;
    logic        fir_s_tready;
    logic [15:0] fir_s_tdata;
    logic        fir_m_tvalid;
    logic [15:0] fir_m_tdata;
    logic        m_tvalid;
    logic [15:0] m_tdata;
    logic [1:0]  m_tuser;
    logic        m_tlast;
    logic        err_underflow;
    logic        err_overflow;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 5;
    logic core_ready = 1'b1;
    logic inj = 1'b0;
    logic [15:0] inj_d = '0;

    logic [15:0] sbq [4][$];
    int  exp_ch = 0;
    bit  mon_en = 1'b1;
    int  t_acc = 0;

    int issue_cnt = 0;
    int ret_cnt = 0;
    int max_occ = 0;
    int snap_issue = -1;

    logic        pv [16];
    logic [15:0] pd [16];

    fir_tdm_sequencer #(.N_CH(4), .DW(16), .MAX_INFLIGHT(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .s_ch_tvalid   (s_ch_tvalid),
        .s_ch_tready   (s_ch_tready),
        .s_ch_tdata    (s_ch_tdata),
        .fir_s_tvalid  (fir_s_tvalid),
        .fir_s_tready  (fir_s_tready),
        .fir_s_tdata   (fir_s_tdata),
        .fir_m_tvalid  (fir_m_tvalid),
        .fir_m_tdata   (fir_m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tdata       (m_tdata),
        .m_tuser       (m_tuser),
        .m_tlast       (m_tlast),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    // Core model: output = input + 1 after lat cycles, always ready unless stalled by the bench.
    assign fir_s_tready = core_ready;
    assign fir_m_tvalid = pv[lat-1] || inj;
    assign fir_m_tdata  = inj ? inj_d : pd[lat-1];

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 16; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= fir_s_tvalid && fir_s_tready;
            pd[0] <= fir_s_tdata + 16'd1;
            for (int i = 1; i < 16; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    always @(posedge aclk) begin
        if (fir_s_tvalid && fir_s_tready) issue_cnt++;
        if (pv[lat-1]) begin
            ret_cnt++;
            if (snap_issue < 0) snap_issue = issue_cnt;
        end
        if (issue_cnt - ret_cnt > max_occ) max_occ = issue_cnt - ret_cnt;
    end

    always @(negedge aclk) begin
        if (mon_en && m_tvalid) begin
            logic [15:0] exp_d;
            n_chk++;
            if (sbq[exp_ch].size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got ch=%0d data=%h, required no output", m_tuser, m_tdata);
            end else begin
                exp_d = sbq[exp_ch].pop_front() + 16'd1;
                if (m_tuser !== 2'(exp_ch) || m_tdata !== exp_d || m_tlast !== (exp_ch == 3)) begin
                    n_fail++;
                    $display("FAIL out_stream: got ch=%0d data=%h last=%b, required ch=%0d data=%h last=%b",
                             m_tuser, m_tdata, m_tlast, exp_ch, exp_d, exp_ch == 3);
                end
            end
            exp_ch = (exp_ch + 1) % 4;
        end
    end

    task automatic load(input logic [3:0] mask, input logic [63:0] dvec);
        logic [3:0] pend;
        int guard;
        pend  = mask;
        guard = 0;
        @(posedge aclk); #1;
        s_ch_tdata  = dvec;
        s_ch_tvalid = mask;
        while (pend != 0 && guard < 100) begin
            @(negedge aclk);
            for (int c = 0; c < 4; c++) begin
                if (pend[c] && s_ch_tready[c]) begin
                    sbq[c].push_back(dvec[c*16 +: 16]);
                    if (c == 0) t_acc = cyc;
                    pend[c] = 1'b0;
                end
            end
            @(posedge aclk); #1;
            s_ch_tvalid = pend;
            guard++;
        end
        n_chk++;
        if (pend != 0) begin
            n_fail++;
            $display("FAIL load_timeout: pending mask %b, required 0000", pend);
        end
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && guard < 300) begin
            @(negedge aclk);
            guard++;
        end
        repeat (3) @(negedge aclk);
        n_chk++;
        if (guard >= 300) begin
            n_fail++;
            $display("FAIL %s_drain: %0d samples outstanding, required 0", name,
                     sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size());
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        enable = 1'b1;
        @(negedge aclk);
        n_chk++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b d=%h u=%0d l=%b, required all 0", m_tvalid, m_tdata, m_tuser, m_tlast);
        end
        n_chk++;
        if (fir_s_tvalid !== 1'b0 || fir_s_tdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_issue: got v=%b d=%h, required 0 0000", fir_s_tvalid, fir_s_tdata);
        end
        n_chk++;
        if (s_ch_tready !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 1111", s_ch_tready);
        end
        n_chk++;
        if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got uf=%b of=%b, required 0 0", err_underflow, err_overflow);
        end
    endtask

    task automatic test_order;
        int t_out;
        t_out = -1;
        load(4'b1111, 64'h0040_0030_0020_0010);
        for (int i = 0; i < 30 && t_out < 0; i++) begin
            @(negedge aclk);
            if (m_tvalid) t_out = cyc;
        end
        n_chk++;
        if (t_out - t_acc != 7) begin
            n_fail++;
            $display("FAIL order_latency: got %0d cycles from accept, required 7", t_out - t_acc);
        end
        wait_drain("order");
    endtask

    task automatic test_stall;
        int hs;
        hs = 0;
        load(4'b1101, 64'h0141_0131_0000_0111);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (fir_s_tvalid && fir_s_tready) hs++;
        end
        n_chk++;
        if (hs != 1 || fir_s_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_gap: got %0d issues, tvalid=%b, required 1 issue, tvalid=0", hs, fir_s_tvalid);
        end
        load(4'b0010, 64'h0000_0000_0121_0000);
        wait_drain("stall");
    endtask

    task automatic test_backpressure;
        @(posedge aclk); #1 core_ready = 1'b0;
        load(4'b1111, 64'h0A04_0A03_0A02_0A01);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_chk++;
            if (fir_s_tvalid !== 1'b1 || fir_s_tdata !== 16'h0A01) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d got v=%b d=%h, required 1 0a01", i, fir_s_tvalid, fir_s_tdata);
            end
            @(posedge aclk);
        end
        #1 core_ready = 1'b1;
        wait_drain("bp");
    endtask

    task automatic test_limit;
        @(posedge aclk); #1 lat = 10;
        @(negedge aclk);
        issue_cnt  = 0;
        ret_cnt    = 0;
        max_occ    = 0;
        snap_issue = -1;
        load(4'b1111, 64'h0B04_0B03_0B02_0B01);
        load(4'b1111, 64'h0C04_0C03_0C02_0C01);
        wait_drain("limit");
        n_chk++;
        if (snap_issue != 4) begin
            n_fail++;
            $display("FAIL limit_first_ret: got %0d issues before first return, required 4", snap_issue);
        end
        n_chk++;
        if (max_occ != 4) begin
            n_fail++;
            $display("FAIL limit_occupancy: got max %0d in flight, required 4", max_occ);
        end
        n_chk++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_err: got of=%b uf=%b, required 0 0", err_overflow, err_underflow);
        end
        @(posedge aclk); #1 lat = 5;
        repeat (12) @(posedge aclk);
    endtask

    task automatic test_error;
        mon_en = 1'b0;
        @(posedge aclk); #1;
        inj   = 1'b1;
        inj_d = 16'h1234;
        @(posedge aclk); #1 inj = 1'b0;
        @(negedge aclk);
        n_chk++;
        if (m_tvalid !== 1'b1 || m_tdata !== 16'h1234 || m_tuser !== 2'(exp_ch) || m_tlast !== (exp_ch == 3)) begin
            n_fail++;
            $display("FAIL uf_output: got v=%b d=%h u=%0d l=%b, required 1 1234 %0d %b",
                     m_tvalid, m_tdata, m_tuser, m_tlast, exp_ch, exp_ch == 3);
        end
        n_chk++;
        if (err_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_flag: got %b, required 1", err_underflow);
        end
        load(4'b0001, 64'h0000_0000_0000_0D01);
        @(negedge aclk);
        n_chk++;
        if (err_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_sticky: got %b, required 1", err_underflow);
        end
        @(posedge aclk); #2 aresetn = 1'b0;
        #1;
        n_chk++;
        if (err_underflow !== 1'b0 || m_tvalid !== 1'b0 || fir_s_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got uf=%b mv=%b fv=%b, required 0 0 0", err_underflow, m_tvalid, fir_s_tvalid);
        end
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        for (int c = 0; c < 4; c++) sbq[c].delete();
        exp_ch = 0;
        mon_en = 1'b1;
        @(negedge aclk);
        n_chk++;
        if (s_ch_tready !== 4'b1111 || fir_s_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got ready=%b fv=%b, required 1111 0", s_ch_tready, fir_s_tvalid);
        end
        load(4'b1111, 64'h0E04_0E03_0E02_0E01);
        wait_drain("post_reset");
    endtask

    initial begin
        test_reset;
        test_order;
        test_stall;
        test_backpressure;
        test_limit;
        test_error;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
